// File: rtl/wdog_bus_if.sv
// Register-port bus between the watchdog bus master and the watchdog block.
interface wdog_bus_if;
  logic        write;
  logic        read;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output write, output read, output addr, output wdata, input rdata);
  modport slave  (input write, input read, input addr, input wdata, output rdata);
endinterface

// File: rtl/wdog_bus_master.sv
// Programs the watchdog timeout, enables it, then kicks it periodically and
// checks STATUS after every kick; a STOP request disables it at the next WAIT.
module wdog_bus_master #(
  parameter int unsigned KICK_PERIOD = 1000,
  parameter logic [31:0] KICK_KEY    = 32'h5A5A_A5A5,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic [31:0] i_timeout,
  input  logic        i_kick_en,
  output logic        o_busy,
  output logic [15:0] o_kick_cnt,
  output logic        o_err,
  wdog_bus_if.master  bus
);

  localparam logic [19:0] LP_PERIOD_LD = 20'(KICK_PERIOD - 1);
  localparam logic [19:0] LP_LAT_LD    = 20'(RD_LAT);

  // IDLE | WR_LOAD | WR_CTRL | WAIT | WR_KICK | RD_STAT | CHK | WR_DIS
  typedef enum logic [2:0] {
    S_IDLE, S_WR_LOAD, S_WR_CTRL, S_WAIT, S_WR_KICK, S_RD_STAT, S_CHK, S_WR_DIS
  } state_t;

  state_t      r_state;
  state_t      w_nxt;
  logic [19:0] r_cnt;
  logic        r_stop_pend;
  logic        w_stop;
  logic        w_cnt_ld;
  logic [19:0] w_cnt_val;
  logic        w_accept;
  logic        w_set_err;
  logic        w_kick_ok;
  logic        w_rdata_unused;

  assign w_stop         = r_stop_pend | i_stop;
  assign w_rdata_unused = ^bus.rdata[31:2];

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    w_cnt_ld  = 1'b0;
    w_cnt_val = LP_PERIOD_LD;
    w_accept  = 1'b0;
    w_set_err = 1'b0;
    w_kick_ok = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_timeout == '0) begin
            w_set_err = 1'b1;
          end else begin
            w_accept = 1'b1;
            w_nxt    = S_WR_LOAD;
          end
        end
      end
      S_WR_LOAD: w_nxt = S_WR_CTRL;
      S_WR_CTRL: begin
        w_cnt_ld = 1'b1;
        w_nxt    = w_stop ? S_WR_DIS : S_WAIT;
      end
      S_WAIT: begin
        if (w_stop) begin
          w_nxt = S_WR_DIS;
        end else if (r_cnt == '0) begin
          // Period elapsed: kick, or restart the period if kicks are withheld.
          w_cnt_ld = 1'b1;
          if (i_kick_en) w_nxt = S_WR_KICK;
        end
      end
      S_WR_KICK: w_nxt = S_RD_STAT;
      S_RD_STAT: begin
        w_cnt_ld  = 1'b1;
        w_cnt_val = LP_LAT_LD;
        w_nxt     = S_CHK;
      end
      S_CHK: begin
        if (r_cnt == '0) begin
          if (bus.rdata[1] || !bus.rdata[0]) begin
            w_set_err = 1'b1;
            w_nxt     = S_IDLE;
          end else begin
            w_kick_ok = 1'b1;
            w_cnt_ld  = 1'b1;
            w_nxt     = w_stop ? S_WR_DIS : S_WAIT;
          end
        end
      end
      S_WR_DIS: w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_cnt_ld) begin
      r_cnt <= w_cnt_val;
    end else if ((r_state == S_WAIT || r_state == S_CHK) && r_cnt != '0) begin
      r_cnt <= r_cnt - 20'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stop_pend <= 1'b0;
    end else if (w_nxt == S_IDLE || w_nxt == S_WR_DIS) begin
      r_stop_pend <= 1'b0;
    end else if (r_state != S_IDLE && i_stop) begin
      r_stop_pend <= 1'b1;
    end
  end

  // Bus outputs are decoded from the next state so they are registered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus.write  <= 1'b0;
      bus.read   <= 1'b0;
      bus.addr   <= 4'h0;
      bus.wdata  <= 32'h0;
      o_busy     <= 1'b0;
      o_kick_cnt <= 16'h0;
      o_err      <= 1'b0;
    end else begin
      bus.write <= 1'b0;
      bus.read  <= 1'b0;
      bus.addr  <= 4'h0;
      bus.wdata <= 32'h0;
      o_busy    <= (w_nxt != S_IDLE);
      case (w_nxt)
        S_WR_LOAD: begin
          bus.write <= 1'b1;
          bus.addr  <= 4'h1;
          bus.wdata <= i_timeout;
        end
        S_WR_CTRL: begin
          bus.write <= 1'b1;
          bus.addr  <= 4'h0;
          bus.wdata <= 32'h1;
        end
        S_WR_KICK: begin
          bus.write <= 1'b1;
          bus.addr  <= 4'h2;
          bus.wdata <= KICK_KEY;
        end
        S_RD_STAT: begin
          bus.read <= 1'b1;
          bus.addr <= 4'h3;
        end
        S_WR_DIS: begin
          bus.write <= 1'b1;
          bus.addr  <= 4'h0;
        end
        default: ;
      endcase

      if (w_accept) begin
        o_kick_cnt <= 16'h0;
      end else if (w_kick_ok && o_kick_cnt != 16'hFFFF) begin
        o_kick_cnt <= o_kick_cnt + 16'd1;
      end

      if (w_accept)       o_err <= 1'b0;
      else if (w_set_err) o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wdog_bus_master.sv
// Scoreboard bench for wdog_bus_master: expected bus accesses are queued with
// their cycle numbers and a negedge monitor pops and compares them.
module tb_wdog_bus_master;
  localparam int          KP  = 8;
  localparam int          RL  = 1;
  localparam logic [31:0] KEY = 32'h5A5A_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        kick_en = 1'b1;
  logic [31:0] timeout = 32'h0;
  logic [31:0] status = 32'h1;
  logic        busy;
  logic [15:0] kick_cnt;
  logic        err;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  wdog_bus_if bus ();
  assign bus.rdata = status;

  wdog_bus_master #(.KICK_PERIOD(KP), .KICK_KEY(KEY), .RD_LAT(RL)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_stop     (stop),
    .i_timeout  (timeout),
    .i_kick_en  (kick_en),
    .o_busy     (busy),
    .o_kick_cnt (kick_cnt),
    .o_err      (err),
    .bus        (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  task automatic push(bit wr, logic [3:0] a, logic [31:0] d, int c);
    exp_t e;
    e.wr = wr; e.addr = a; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_start(logic [31:0] to);
    timeout = to;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_write"}, 32'(bus.write), 32'h0);
    check({tag, "_read"}, 32'(bus.read), 32'h0);
    check({tag, "_addr"}, 32'(bus.addr), 32'h0);
    check({tag, "_wdata"}, bus.wdata, 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_kick_cnt"}, 32'(kick_cnt), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("strobe_overlap", 32'(bus.write & bus.read), 32'h0);
      if (!bus.write && !bus.read) begin
        check("idle_addr", 32'(bus.addr), 32'h0);
        check("idle_wdata", bus.wdata, 32'h0);
      end else if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_access cyc=%0d actual=wr%0b/rd%0b addr=%h data=%h required=none",
                 cyc, bus.write, bus.read, bus.addr, bus.wdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (bus.write !== e.wr || bus.read !== !e.wr || bus.addr !== e.addr ||
            (e.wr && bus.wdata !== e.data) || cyc != e.cyc) begin
          failures++;
          $display("FAIL bus_access actual=wr%0b/rd%0b addr=%h data=%h cyc=%0d required=wr%0b addr=%h data=%h cyc=%0d",
                   bus.write, bus.read, bus.addr, bus.wdata, cyc, e.wr, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    int s;
    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    mon_en = 1'b1;
    wait_cyc(cyc + 2);

    // Normal run: three good kicks, then STOP mid-WAIT
    status = 32'h1;
    kick_en = 1'b1;
    check("pre_start_busy", 32'(busy), 32'h0);
    s = cyc + 1;
    push(1, 4'h1, 32'h0000_0100, s);
    push(1, 4'h0, 32'h1, s + 1);
    for (int k = 0; k < 3; k++) begin
      push(1, 4'h2, KEY, s + 10 + 12 * k);
      push(0, 4'h3, 32'h0, s + 11 + 12 * k);
    end
    pulse_start(32'h0000_0100);
    for (int c = s; c <= s + 40; c++) begin
      wait_cyc(c);
      check("busy_run", 32'(busy), 32'h1);
      if (c == s + 13) check("kick_cnt_before_first", 32'(kick_cnt), 32'h0);
      if (c == s + 14) check("kick_cnt_after_first", 32'(kick_cnt), 32'h1);
    end
    check("kick_cnt_three", 32'(kick_cnt), 32'h3);
    check("err_run", 32'(err), 32'h0);
    push(1, 4'h0, 32'h0, s + 41);
    pulse_stop();
    wait_cyc(s + 42);
    check("stop_busy_low", 32'(busy), 32'h0);
    wait_cyc(s + 43);
    check("stop_queue_empty", exp_q.size(), 0);

    // STOP during WR_KICK: read and check finish before the disable write
    wait_cyc(cyc + 3);
    s = cyc + 1;
    push(1, 4'h1, 32'h0000_0040, s);
    push(1, 4'h0, 32'h1, s + 1);
    push(1, 4'h2, KEY, s + 10);
    push(0, 4'h3, 32'h0, s + 11);
    push(1, 4'h0, 32'h0, s + 14);
    pulse_start(32'h0000_0040);
    wait_cyc(s + 10);
    pulse_stop();
    wait_cyc(s + 14);
    check("kstop_busy_dis", 32'(busy), 32'h1);
    wait_cyc(s + 15);
    check("kstop_busy_low", 32'(busy), 32'h0);
    check("kstop_kick_cnt", 32'(kick_cnt), 32'h1);
    check("kstop_err", 32'(err), 32'h0);
    wait_cyc(s + 18);
    check("kstop_queue_empty", exp_q.size(), 0);

    // START with TIMEOUT=0: error flagged, no bus traffic, stays idle
    wait_cyc(cyc + 2);
    check("zero_err_before", 32'(err), 32'h0);
    s = cyc + 1;
    pulse_start(32'h0);
    check("zero_err", 32'(err), 32'h1);
    check("zero_busy", 32'(busy), 32'h0);
    wait_cyc(s + 6);
    check("zero_busy_later", 32'(busy), 32'h0);

    // KICK_EN low starves the watchdog for over 3 periods, then resumes
    kick_en = 1'b0;
    s = cyc + 1;
    push(1, 4'h1, 32'h0000_0200, s);
    push(1, 4'h0, 32'h1, s + 1);
    pulse_start(32'h0000_0200);
    check("starve_err_cleared", 32'(err), 32'h0);
    wait_cyc(s + 28);
    check("starve_kick_cnt", 32'(kick_cnt), 32'h0);
    check("starve_busy", 32'(busy), 32'h1);
    push(1, 4'h2, KEY, s + 34);
    push(0, 4'h3, 32'h0, s + 35);
    kick_en = 1'b1;
    wait_cyc(s + 40);
    check("resume_kick_cnt", 32'(kick_cnt), 32'h1);
    push(1, 4'h0, 32'h0, s + 41);
    pulse_stop();
    wait_cyc(s + 43);
    check("starve_queue_empty", exp_q.size(), 0);

    // STATUS reports expired on the first read
    wait_cyc(cyc + 3);
    status = 32'h3;
    s = cyc + 1;
    push(1, 4'h1, 32'h0000_0100, s);
    push(1, 4'h0, 32'h1, s + 1);
    push(1, 4'h2, KEY, s + 10);
    push(0, 4'h3, 32'h0, s + 11);
    pulse_start(32'h0000_0100);
    wait_cyc(s + 13);
    check("expired_busy_chk", 32'(busy), 32'h1);
    wait_cyc(s + 14);
    check("expired_busy_low", 32'(busy), 32'h0);
    check("expired_err", 32'(err), 32'h1);
    check("expired_kick_cnt", 32'(kick_cnt), 32'h0);
    wait_cyc(s + 34);
    check("expired_err_sticky", 32'(err), 32'h1);
    check("expired_queue_empty", exp_q.size(), 0);

    // RST during CHK, then a full replay
    status = 32'h1;
    s = cyc + 1;
    push(1, 4'h1, 32'h0000_0055, s);
    push(1, 4'h0, 32'h1, s + 1);
    push(1, 4'h2, KEY, s + 10);
    push(0, 4'h3, 32'h0, s + 11);
    pulse_start(32'h0000_0055);
    wait_cyc(s + 12);
    check("rst_chk_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    wait_cyc(cyc + 3);
    check("midrst_queue_empty", exp_q.size(), 0);
    s = cyc + 1;
    push(1, 4'h1, 32'h0000_0077, s);
    push(1, 4'h0, 32'h1, s + 1);
    push(1, 4'h2, KEY, s + 10);
    push(0, 4'h3, 32'h0, s + 11);
    push(1, 4'h0, 32'h0, s + 21);
    pulse_start(32'h0000_0077);
    wait_cyc(s + 20);
    check("replay_kick_cnt", 32'(kick_cnt), 32'h1);
    pulse_stop();
    wait_cyc(s + 23);
    check("replay_busy_low", 32'(busy), 32'h0);
    check("final_queue_empty", exp_q.size(), 0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wdog_bus_master.md
# wdog_bus_master

Bus initiator that drives the watchdog block's register port (ADDR/WDATA/WRITE, RDATA) from the system side. On command it programs the timeout, enables the watchdog, then services it with periodic kick writes, reads back status after each kick and flags anomalies. It sits between the supervisor logic and the watchdog top, and is also the stimulus engine for watchdog regression.

## Interface

Parameters:
- KICK_PERIOD, 1000: cycles spent in WAIT between kicks; legal range 1..2^20-1.
- KICK_KEY, 32'h5A5A_A5A5: data value written to the KICK register.
- RD_LAT, 1: cycles from the READ strobe to valid RDATA; legal range 1..4.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  one-cycle pulse; begins the programming sequence. Ignored unless in IDLE.
- STOP  in  1  one-cycle pulse; requests a disable and return to IDLE.
- TIMEOUT  in  32  watchdog load value; latched on the accepted START.
- KICK_EN  in  1  level; when low, kicks are withheld so the watchdog can be starved deliberately.
- WRITE  out  1  single-cycle write strobe to the watchdog.
- READ  out  1  single-cycle read strobe to the watchdog.
- ADDR  out  4  register address.
- WDATA  out  32  write data.
- RDATA  in  32  read data from the watchdog.
- BUSY  out  1  high in every state except IDLE.
- KICK_CNT  out  16  count of successful kicks; saturates at 16'hFFFF.
- ERR  out  1  sticky error flag.

## Operation

- Register map driven by this block: 0x0 CTRL (bit0 = enable), 0x1 LOAD, 0x2 KICK, 0x3 STATUS (bit0 = enabled, bit1 = expired).
- States: IDLE, WR_LOAD, WR_CTRL, WAIT, WR_KICK, RD_STAT, CHK, WR_DIS.
- IDLE, START accepted: latch TIMEOUT, clear ERR and KICK_CNT, go to WR_LOAD.
  - If TIMEOUT == 0: set ERR instead, stay in IDLE, issue no bus access.
- WR_LOAD: WRITE=1, ADDR=1, WDATA=latched TIMEOUT. Next state WR_CTRL.
- WR_CTRL: WRITE=1, ADDR=0, WDATA=1. Next state WAIT, with the period counter cleared.
- WAIT: count cycles. On reaching KICK_PERIOD:
  - If KICK_EN=1: go to WR_KICK.
  - If KICK_EN=0: restart the count and remain in WAIT.
- WR_KICK: WRITE=1, ADDR=2, WDATA=KICK_KEY. Next state RD_STAT.
- RD_STAT: READ=1, ADDR=3 for one cycle, then CHK.
- CHK: hold for RD_LAT cycles, then sample RDATA.
  - If bit1=1 or bit0=0: set ERR and go to IDLE. No disable write is issued.
  - Otherwise: increment KICK_CNT (saturating) and go to WAIT.
- STOP:
  - Latched as pending in any non-IDLE state.
  - Acted on when in WAIT (immediately) or on the next entry to WAIT. Go to WR_DIS: WRITE=1, ADDR=0, WDATA=0, then IDLE.
  - In IDLE, STOP is ignored and not latched.
  - STOP and START in the same IDLE cycle: START wins and STOP is discarded.
- An in-flight access (WR_*, RD_STAT, CHK) is never aborted by STOP.
- ERR stays set until the next accepted START or RST.

## Timing

- Reset values: WRITE=0, READ=0, ADDR=0, WDATA=0, BUSY=0, KICK_CNT=0, ERR=0, state IDLE, STOP-pending cleared.
- Bus outputs are registered. WRITE/READ are high for exactly one cycle per access and never high together.
- When neither strobe is high, ADDR and WDATA are 0.
- START accepted at edge N: WRITE to LOAD in cycle N+1, WRITE to CTRL in N+2, first WAIT cycle N+3.
- BUSY rises in cycle N+1.
- First kick WRITE occurs in cycle N+3+KICK_PERIOD (KICK_EN=1).
- Kick-to-kick spacing is KICK_PERIOD+3+RD_LAT cycles.
- RST asserted mid-sequence: all outputs take reset values at the next edge; no disable write is issued.

## Test plan

- START with TIMEOUT=32'h0000_0100, KICK_PERIOD=8, RD_LAT=1 -> write (1, 0x100) at N+1, write (0, 1) at N+2, write (2, 5A5A_A5A5) at N+11, READ of addr 3 at N+12, BUSY=1 throughout.
- STATUS returns 32'h1 on each read for 3 kicks -> KICK_CNT=3, ERR=0, kicks spaced 12 cycles apart.
- STATUS returns 32'h3 on the first read -> ERR=1, BUSY=0 on the following cycle, no further bus writes.
- STOP pulsed mid-WAIT -> next cycle write (0, 0), then IDLE with BUSY=0; STOP pulsed during WR_KICK -> RD_STAT/CHK complete first, then write (0, 0).
- KICK_EN=0 for 3×KICK_PERIOD -> no writes to addr 2, KICK_CNT unchanged; START with TIMEOUT=0 -> ERR=1, no WRITE at all.
- RST asserted in CHK -> next cycle every output at its reset value; a subsequent START replays the full sequence.
